lfsr_encrypt: RTL
=================

LFSR_ENCRYPT -- requirements
Module: lfsr_encrypt

Interface
REQ-001 SHALL provide parameter: PRE_LEN, 7, number of 0x5F preamble bytes before the message (legal range 1..16).
REQ-002 SHALL provide parameter: MSG_BASE, 0, data-memory address of plaintext byte 0.
REQ-003 SHALL provide parameter: ENC_BASE, 64, data-memory address of encrypted byte 0.
REQ-004 SHALL provide port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL provide port: init_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL provide port: start  input  1  request a 64-byte encryption run; sampled in IDLE only.
REQ-007 SHALL provide port: seed  input  6  LFSR starting state.
REQ-008 SHALL provide port: tap_sel  input  3  selects a tap pattern: 0..5 = 6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39.
REQ-009 SHALL provide port: msg_len  input  7  number of plaintext bytes to encrypt.
REQ-010 SHALL provide port: mem_raddr  output  8  plaintext read address.
REQ-011 SHALL provide port: mem_rdata  input  8  plaintext read data; combinational read, valid in the same cycle.
REQ-012 SHALL provide ports: mem_wr_en  output  1, mem_waddr  output  8, mem_wdata  output  8  encrypted-byte write port.
REQ-013 SHALL provide ports: busy  output  1, done  output  1, seed_err  output  1  status.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, RUN and DONE; IDLE->LOAD when start=1; LOAD->RUN after 1 cycle; RUN->DONE after byte k=63; DONE->IDLE after 1 cycle.
REQ-015 In LOAD, SHALL latch tap_sel, msg_len and seed; SHALL load the LFSR with the latched seed and clear the byte index k.
REQ-016 Tap selection: tap_sel values 6 and 7 SHALL select pattern 6'h21.
REQ-017 Zero seed: if seed=0, SHALL substitute 6'h01 and set seed_err=1 until the next LOAD.
REQ-018 LFSR update in RUN, each cycle: state <= {state[4:0], ^(state & taps)}.
REQ-019 Plaintext byte selection, per k: 8'h5F if k<PRE_LEN; else mem_rdata if k-PRE_LEN < L; else 8'h20 (space pad).
REQ-020 Effective length: L = min(msg_len, 64-PRE_LEN).
REQ-021 Read address: mem_raddr SHALL be MSG_BASE+(k-PRE_LEN) while reading a message byte, and 0 otherwise.
REQ-022 In RUN, SHALL drive mem_wr_en=1, mem_waddr=ENC_BASE+k and mem_wdata={p[7:6], p[5:0]^state}, one byte per cycle; mem_wr_en SHALL be 0 in every other state.
REQ-023 Encrypted byte 0 SHALL equal 8'h5F^{2'b0,seed}, so that the receiver recovers seed as byte0[5:0]^6'h1F.
REQ-024 Latency: start sampled at edge T; first write in cycle T+2; last write in T+65; done=1 for exactly one cycle, T+66.
REQ-025 busy SHALL be 1 in LOAD, RUN and DONE.
REQ-026 start asserted while busy=1 SHALL be ignored; start held high SHALL begin a new run only after returning to IDLE.
REQ-027 Writes SHALL never leave the range ENC_BASE..ENC_BASE+63.
REQ-028 The index k SHALL not wrap within a run.

Reset
REQ-029 On init_n=0, immediately and independent of clk: state=IDLE, k=0, LFSR=6'h01, and all outputs 0 (mem_wr_en, mem_waddr, mem_wdata, mem_raddr, busy, done, seed_err).
REQ-030 Reset mid-RUN SHALL abort the run with no further writes; a run started after reset SHALL be a complete 64-byte run.

Configuration
REQ-031 Macro PARITY_EN defined: mem_wdata[7] SHALL be ^mem_wdata[6:0] (even parity over the encrypted byte).
REQ-032 PARITY_EN undefined: mem_wdata[7] SHALL be p[7], unchanged from the plaintext.

Verification
REQ-033 seed=6'h01, tap_sel=0, PRE_LEN=7, msg_len=1, mem[0]=8'h41 -> mem[64]=8'h5E, mem[65]=8'h5C, mem[71]=8'h41^state7; decrypting the 64 bytes returns 7x 8'h5F, 8'h41, then 56x 8'h20.
REQ-034 msg_len=0 -> mem[71..127] = {2'b00, 6'h20^state_k} for each k; mem_raddr stays 0 for the whole run.
REQ-035 seed=0 -> seed_err=1 and output identical to the seed=6'h01 run; the next start with seed=6'h05 clears seed_err.
REQ-036 init_n pulled low during RUN at k=20 -> mem_wr_en=0 and busy=0 without a clock edge; a fresh start produces all 64 writes and exactly one done.
REQ-037 start held high for 200 cycles -> runs begin at T and T+67, each with exactly one done pulse; msg_len=100 is clipped to 57.
REQ-038 PARITY_EN build, seed=6'h01 -> mem[64]=8'hDE; non-PARITY_EN build -> mem[64]=8'h5E.

Source files
------------

// File: rtl/lfsr_encrypt_if.sv
// Bus between the LFSR encryption engine and its host: run control, plaintext
// read port, ciphertext write port and status.
interface lfsr_encrypt_if;
  logic       start;
  logic [5:0] seed;
  logic [2:0] tap_sel;
  logic [6:0] msg_len;
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic       seed_err;

  modport master (
    output start, seed, tap_sel, msg_len, mem_rdata,
    input  mem_raddr, mem_wr_en, mem_waddr, mem_wdata, busy, done, seed_err
  );

  modport slave (
    input  start, seed, tap_sel, msg_len, mem_rdata,
    output mem_raddr, mem_wr_en, mem_waddr, mem_wdata, busy, done, seed_err
  );
endinterface

// File: rtl/lfsr_encrypt.sv
// Encrypts a 64-byte frame (0x5F preamble, message, space pad) with a 6-bit LFSR.
// Optional build macro PARITY_EN replaces bit 7 of each output byte with even parity.
module lfsr_encrypt #(
  parameter int PRE_LEN  = 7,
  parameter int MSG_BASE = 0,
  parameter int ENC_BASE = 64
) (
  input logic          clk,
  input logic          init_n,
  lfsr_encrypt_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [6:0] PRE     = 7'(PRE_LEN);
  localparam logic [6:0] MAX_LEN = 7'(64 - PRE_LEN);
  localparam logic [7:0] MSG_B   = 8'(MSG_BASE);
  localparam logic [7:0] ENC_B   = 8'(ENC_BASE);

  state_t     state, state_nxt;
  logic [5:0] k, lfsr, taps;
  logic [2:0] tap_q;
  logic [6:0] len_q, eff_len, k7, idx;
  logic       seed_err_q, is_pre, is_msg;
  logic [7:0] plain, cipher, cipher_out;
  logic       wr_en, busy, done;
  logic [7:0] waddr, wdata, raddr;

  always_comb begin
    case (tap_q)
      3'd1:    taps = 6'h2D;
      3'd2:    taps = 6'h30;
      3'd3:    taps = 6'h33;
      3'd4:    taps = 6'h36;
      3'd5:    taps = 6'h39;
      default: taps = 6'h21;
    endcase
  end

  // Frame layout: preamble, clipped message, then pad to 64 bytes.
  assign eff_len = (len_q > MAX_LEN) ? MAX_LEN : len_q;
  assign k7      = {1'b0, k};
  assign idx     = k7 - PRE;
  assign is_pre  = k7 < PRE;
  assign is_msg  = !is_pre && (idx < eff_len);
  assign plain   = is_pre ? 8'h5F : (is_msg ? bus.mem_rdata : 8'h20);
  assign cipher  = {plain[7:6], plain[5:0] ^ lfsr};

`ifdef PARITY_EN
  assign cipher_out = {^cipher[6:0], cipher[6:0]};
`else
  assign cipher_out = cipher;
`endif

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    waddr     = 8'h00;
    wdata     = 8'h00;
    raddr     = 8'h00;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_nxt = LOAD;
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        wr_en = 1'b1;
        waddr = ENC_B + {2'b00, k};
        wdata = cipher_out;
        if (is_msg) raddr = MSG_B + {1'b0, idx};
        if (k == 6'd63) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      k          <= 6'd0;
      lfsr       <= 6'h01;
      tap_q      <= 3'd0;
      len_q      <= 7'd0;
      seed_err_q <= 1'b0;
    end else if (state == LOAD) begin
      k          <= 6'd0;
      tap_q      <= bus.tap_sel;
      len_q      <= bus.msg_len;
      // An all-zero LFSR would lock up, so zero seeds are forced to 1 and flagged.
      lfsr       <= (bus.seed == 6'd0) ? 6'h01 : bus.seed;
      seed_err_q <= (bus.seed == 6'd0);
    end else if (state == RUN) begin
      lfsr <= {lfsr[4:0], ^(lfsr & taps)};
      if (k != 6'd63) k <= k + 6'd1;
    end
  end

  assign bus.mem_wr_en = wr_en;
  assign bus.mem_waddr = waddr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_raddr = raddr;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.seed_err  = seed_err_q;
endmodule
